// File: rtl/bus_transfer_ctrl_pkg.sv
// rtl/bus_transfer_ctrl_pkg.sv - shared FSM state encodings and default parameters
package bus_transfer_ctrl_pkg;

   localparam int LP_REG_COUNT = 4;
   localparam int LP_IDX_WIDTH = 2;
   localparam int LP_CNT_WIDTH = 16;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_DRIVE  = 3'd1,
      ST_COMMIT = 3'd2,
      ST_DONE   = 3'd3,
      ST_ERR    = 3'd4
   } state_t;

endpackage

// File: rtl/bus_transfer_ctrl_onehot_decoder.sv
// rtl/bus_transfer_ctrl_onehot_decoder.sv - gated index to one-hot decoder
module onehot_decoder #(
   parameter int p_idx_width = 2,
   parameter int p_out_width = 4
) (
   input  logic                   i_w_en,
   input  logic [p_idx_width-1:0] i_w_idx,
   output logic [p_out_width-1:0] o_w_onehot
);

   always_comb begin
      o_w_onehot = '0;
      for (int i = 0; i < p_out_width; i++) begin
         if (i_w_en && (i_w_idx == p_idx_width'(i))) begin
            o_w_onehot[i] = 1'b1;
         end
      end
   end

endmodule

// File: rtl/bus_transfer_ctrl.sv
// rtl/bus_transfer_ctrl.sv - register-to-register bus transfer sequencer
module bus_transfer_ctrl
   import bus_transfer_ctrl_pkg::*;
#(
   parameter int p_reg_count = LP_REG_COUNT,
   parameter int p_idx_width = LP_IDX_WIDTH,
   parameter int p_cnt_width = LP_CNT_WIDTH
) (
   input  logic                   i_w_clk,
   input  logic                   i_w_reset,
   input  logic                   i_w_req_valid,
   output logic                   o_w_req_ready,
   input  logic [p_idx_width-1:0] i_w_src,
   input  logic [p_idx_width-1:0] i_w_dst,
   output logic [p_reg_count-1:0] o_w_oe,
   output logic [p_reg_count-1:0] o_w_we,
   output logic                   o_w_done,
   output logic                   o_w_err,
   output logic [p_cnt_width-1:0] o_w_xfer_count
);

   localparam logic [p_idx_width:0] LP_LIMIT = (p_idx_width + 1)'(p_reg_count);

   state_t                   r_state;
   state_t                   w_next;
   logic [p_idx_width-1:0]   r_src;
   logic [p_idx_width-1:0]   r_dst;
   logic                     r_counts;
   logic                     r_ready_en;
   logic [p_cnt_width-1:0]   r_xfer_count;
   logic                     w_accept;
   logic                     w_bad_idx;
   logic                     w_same;
   logic                     w_oe_en;
   logic                     w_we_en;

   // r_ready_en keeps ready low until the first edge after reset release
   assign o_w_req_ready  = (r_state == ST_IDLE) && r_ready_en;
   assign w_accept       = i_w_req_valid && o_w_req_ready;
   assign w_bad_idx      = ({1'b0, i_w_src} >= LP_LIMIT) || ({1'b0, i_w_dst} >= LP_LIMIT);
   assign w_same         = (i_w_src == i_w_dst);
   assign o_w_xfer_count = r_xfer_count;

   always_ff @(posedge i_w_clk or posedge i_w_reset) begin
      if (i_w_reset) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   always_comb begin
      w_next   = r_state;
      w_oe_en  = 1'b0;
      w_we_en  = 1'b0;
      o_w_done = 1'b0;
      o_w_err  = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (w_accept) begin
               if (w_bad_idx)   w_next = ST_ERR;
               else if (w_same) w_next = ST_DONE;
               else             w_next = ST_DRIVE;
            end
         end
         ST_DRIVE: begin
            w_oe_en = 1'b1;
            w_next  = ST_COMMIT;
         end
         ST_COMMIT: begin
            w_oe_en = 1'b1;
            w_we_en = 1'b1;
            w_next  = ST_DONE;
         end
         ST_DONE: begin
            o_w_done = 1'b1;
            w_next   = ST_IDLE;
         end
         ST_ERR: begin
            o_w_err = 1'b1;
            w_next  = ST_IDLE;
         end
         default: w_next = ST_IDLE;
      endcase
   end

   // r_counts marks a real bus move so trivial and rejected requests leave the count alone
   always_ff @(posedge i_w_clk or posedge i_w_reset) begin
      if (i_w_reset) begin
         r_src        <= '0;
         r_dst        <= '0;
         r_counts     <= 1'b0;
         r_ready_en   <= 1'b0;
         r_xfer_count <= '0;
      end else begin
         r_ready_en <= 1'b1;
         if (w_accept) begin
            r_src    <= i_w_src;
            r_dst    <= i_w_dst;
            r_counts <= !w_bad_idx && !w_same;
         end
         if ((r_state == ST_DONE) && r_counts) begin
            r_xfer_count <= r_xfer_count + p_cnt_width'(1);
         end
      end
   end

   onehot_decoder #(
      .p_idx_width (p_idx_width),
      .p_out_width (p_reg_count)
   ) u_oe_dec (
      .i_w_en     (w_oe_en),
      .i_w_idx    (r_src),
      .o_w_onehot (o_w_oe)
   );

   onehot_decoder #(
      .p_idx_width (p_idx_width),
      .p_out_width (p_reg_count)
   ) u_we_dec (
      .i_w_en     (w_we_en),
      .i_w_idx    (r_dst),
      .o_w_onehot (o_w_we)
   );

endmodule

// File: tb/tb_bus_transfer_ctrl.sv
// tb/tb_bus_transfer_ctrl.sv - directed self-checking bench for bus_transfer_ctrl
module tb_bus_transfer_ctrl;
   import bus_transfer_ctrl_pkg::*;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic valid = 1'b0;
   logic v3 = 1'b0;
   logic vw = 1'b0;
   logic [LP_IDX_WIDTH-1:0] src = '0;
   logic [LP_IDX_WIDTH-1:0] dst = '0;

   logic              ready, done, err;
   logic [3:0]        oe, we;
   logic [15:0]       cnt;
   logic              ready3, done3, err3;
   logic [2:0]        oe3, we3;
   logic [15:0]       cnt3;
   logic              readyw, donew, errw;
   logic [3:0]        oew, wew;
   logic [1:0]        cntw;

   int n_checks = 0;
   int n_errors = 0;

   always #5 clk = ~clk;

   bus_transfer_ctrl dut (
      .i_w_clk(clk), .i_w_reset(rst), .i_w_req_valid(valid), .o_w_req_ready(ready),
      .i_w_src(src), .i_w_dst(dst), .o_w_oe(oe), .o_w_we(we),
      .o_w_done(done), .o_w_err(err), .o_w_xfer_count(cnt)
   );

   bus_transfer_ctrl #(.p_reg_count(3)) dut3 (
      .i_w_clk(clk), .i_w_reset(rst), .i_w_req_valid(v3), .o_w_req_ready(ready3),
      .i_w_src(src), .i_w_dst(dst), .o_w_oe(oe3), .o_w_we(we3),
      .o_w_done(done3), .o_w_err(err3), .o_w_xfer_count(cnt3)
   );

   bus_transfer_ctrl #(.p_cnt_width(2)) dut_w (
      .i_w_clk(clk), .i_w_reset(rst), .i_w_req_valid(vw), .o_w_req_ready(readyw),
      .i_w_src(src), .i_w_dst(dst), .o_w_oe(oew), .o_w_we(wew),
      .o_w_done(donew), .o_w_err(errw), .o_w_xfer_count(cntw)
   );

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   initial begin
      tick;
      tick;
      check_eq("rst_ready", 32'(ready), 0);
      check_eq("rst_oe", 32'(oe), 0);
      check_eq("rst_we", 32'(we), 0);
      check_eq("rst_done", 32'(done), 0);
      check_eq("rst_err", 32'(err), 0);
      check_eq("rst_cnt", 32'(cnt), 0);
      rst = 1'b0;
      check_eq("rel_ready_low", 32'(ready), 0);
      tick;
      check_eq("rel_ready_high", 32'(ready), 1);

      valid = 1'b1; src = 2'd1; dst = 2'd3;
      tick;
      valid = 1'b0; src = 2'd0; dst = 2'd0;
      check_eq("n_drive_oe", 32'(oe), 32'h2);
      check_eq("n_drive_we", 32'(we), 0);
      check_eq("n_drive_ready", 32'(ready), 0);
      tick;
      check_eq("n_commit_oe", 32'(oe), 32'h2);
      check_eq("n_commit_we", 32'(we), 32'h8);
      tick;
      check_eq("n_done", 32'(done), 1);
      check_eq("n_done_oe", 32'(oe), 0);
      check_eq("n_done_cnt", 32'(cnt), 0);
      tick;
      check_eq("n_idle_cnt", 32'(cnt), 1);
      check_eq("n_idle_done", 32'(done), 0);
      check_eq("n_idle_ready", 32'(ready), 1);

      valid = 1'b1; src = 2'd2; dst = 2'd2;
      tick;
      valid = 1'b0;
      check_eq("s_done", 32'(done), 1);
      check_eq("s_oe", 32'(oe), 0);
      check_eq("s_we", 32'(we), 0);
      tick;
      check_eq("s_cnt", 32'(cnt), 1);
      check_eq("s_ready", 32'(ready), 1);

      v3 = 1'b1; src = 2'd3; dst = 2'd0;
      tick;
      v3 = 1'b0;
      check_eq("e_err", 32'(err3), 1);
      check_eq("e_oe", 32'(oe3), 0);
      check_eq("e_we", 32'(we3), 0);
      check_eq("e_ready", 32'(ready3), 0);
      tick;
      check_eq("e_err_clr", 32'(err3), 0);
      check_eq("e_ready_back", 32'(ready3), 1);
      check_eq("e_cnt", 32'(cnt3), 0);
      check_eq("e_done", 32'(done3), 0);

      valid = 1'b1; src = 2'd0; dst = 2'd1;
      for (int k = 0; k <= 12; k++) begin
         check_eq($sformatf("h_ready_%0d", k), 32'(ready), (k % 4 == 0) ? 1 : 0);
         case (k)
            1: begin
               check_eq("h1_oe", 32'(oe), 32'h1);
               src = 2'd2; dst = 2'd3;
            end
            2: begin
               check_eq("h2_oe", 32'(oe), 32'h1);
               check_eq("h2_we", 32'(we), 32'h2);
            end
            3: check_eq("h3_done", 32'(done), 1);
            5: begin
               check_eq("h5_oe", 32'(oe), 32'h4);
               src = 2'd3; dst = 2'd0;
            end
            6: check_eq("h6_we", 32'(we), 32'h8);
            9: begin
               check_eq("h9_oe", 32'(oe), 32'h8);
               valid = 1'b0;
            end
            10: check_eq("h10_we", 32'(we), 32'h1);
            11: check_eq("h11_done", 32'(done), 1);
            12: check_eq("h12_cnt", 32'(cnt), 4);
            default: ;
         endcase
         if (k < 12) tick;
      end

      valid = 1'b1; src = 2'd3; dst = 2'd2;
      tick;
      valid = 1'b0;
      check_eq("r_drive_oe", 32'(oe), 32'h8);
      tick;
      check_eq("r_commit_we", 32'(we), 32'h4);
      rst = 1'b1;
      #1;
      check_eq("r_oe_drop", 32'(oe), 0);
      check_eq("r_we_drop", 32'(we), 0);
      check_eq("r_cnt_clr", 32'(cnt), 0);
      check_eq("r_ready_low", 32'(ready), 0);
      tick;
      check_eq("r_no_done", 32'(done), 0);
      tick;
      rst = 1'b0;
      check_eq("r_rel_ready_low", 32'(ready), 0);
      tick;
      check_eq("r_rel_ready", 32'(ready), 1);
      check_eq("r_rel_done", 32'(done), 0);
      check_eq("r_rel_cnt", 32'(cnt), 0);

      for (int i = 0; i < 5; i++) begin
         vw = 1'b1; src = 2'd0; dst = 2'd1;
         tick;
         vw = 1'b0;
         tick;
         tick;
         tick;
         check_eq($sformatf("w_cnt_%0d", i), 32'(cntw), 32'((i + 1) % 4));
      end

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
